// File: rtl/id_operand_buffer.sv
// ============================================================================
// Module   : id_operand_buffer
// Purpose  : In-order operand-capture buffer between decode and execute.
//            Operands that are not yet valid snoop the result-broadcast
//            channels until they are captured.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_operand_buffer #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 7,
  parameter int DEPTH = 4,
  parameter int NCDB  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [XLEN+TAG_W:0]          in_op1,
  input  logic [XLEN+TAG_W:0]          in_op2,
  input  logic [NCDB-1:0]              cdb_valid,
  input  logic [NCDB*TAG_W-1:0]        cdb_tag,
  input  logic [NCDB*XLEN-1:0]         cdb_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [XLEN-1:0]              out_rs1,
  output logic [XLEN-1:0]              out_rs2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int OPW   = 1 + TAG_W + XLEN;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Returns the operand after one cycle of snooping. Channels are scanned
  // from high to low so the lowest matching index is the one that sticks.
  function automatic logic [OPW-1:0] snoop(
    input logic [OPW-1:0]        op,
    input logic [NCDB-1:0]       v,
    input logic [NCDB*TAG_W-1:0] tags,
    input logic [NCDB*XLEN-1:0]  datas
  );
    logic [OPW-1:0] r;
    r = op;
    if (!op[OPW-1]) begin
      for (int k = NCDB - 1; k >= 0; k--) begin
        if (v[k] && (tags[k*TAG_W +: TAG_W] == op[OPW-2:XLEN])) begin
          r = {1'b1, op[OPW-2:XLEN], datas[k*XLEN +: XLEN]};
        end
      end
    end
    return r;
  endfunction

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic [OPW-1:0]   op1_q   [DEPTH];
  logic [OPW-1:0]   op1_d   [DEPTH];
  logic [OPW-1:0]   op2_q   [DEPTH];
  logic [OPW-1:0]   op2_d   [DEPTH];
  logic [OPW-1:0]   w_op1_wake [DEPTH];
  logic [OPW-1:0]   w_op2_wake [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             w_enq;
  logic             w_deq;
  logic [OPW-1:0]   w_in_op1;
  logic [OPW-1:0]   w_in_op2;

  // Unoccupied slots snoop too; harmless, since enqueue overwrites them.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign w_op1_wake[i] = snoop(op1_q[i], cdb_valid, cdb_tag, cdb_data);
      assign w_op2_wake[i] = snoop(op2_q[i], cdb_valid, cdb_tag, cdb_data);
    end
  endgenerate

  assign w_in_op1 = snoop(in_op1, cdb_valid, cdb_tag, cdb_data);
  assign w_in_op2 = snoop(in_op2, cdb_valid, cdb_tag, cdb_data);

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0) && op1_q[rd_ptr_q][OPW-1] && op2_q[rd_ptr_q][OPW-1];
  assign out_instr = instr_q[rd_ptr_q];
  assign out_rs1   = op1_q[rd_ptr_q][XLEN-1:0];
  assign out_rs2   = op2_q[rd_ptr_q][XLEN-1:0];
  assign count     = count_q;

  assign w_enq = in_valid && in_ready;
  assign w_deq = out_valid && out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(w_deq);
    wr_ptr_d = wr_ptr_q + PTR_W'(w_enq);
    count_d  = count_q + CNT_W'(w_enq) - CNT_W'(w_deq);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      instr_d[i] = instr_q[i];
      op1_d[i]   = w_op1_wake[i];
      op2_d[i]   = w_op2_wake[i];
    end
    if (w_enq && !flush) begin
      instr_d[wr_ptr_q] = in_instr;
      op1_d[wr_ptr_q]   = w_in_op1;
      op2_d[wr_ptr_q]   = w_in_op2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is never reset: only occupancy decides what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      instr_q[i] <= instr_d[i];
      op1_q[i]   <= op1_d[i];
      op2_q[i]   <= op2_d[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_operand_buffer.sv
// ============================================================================
// Module   : tb_id_operand_buffer
// Purpose  : Directed self-checking bench for id_operand_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_operand_buffer;

  localparam int XLEN  = 32;
  localparam int TAG_W = 7;
  localparam int DEPTH = 4;
  localparam int NCDB  = 2;
  localparam int OPW   = 1 + TAG_W + XLEN;

  logic                       clk;
  logic                       rst;
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [31:0]                in_instr;
  logic [OPW-1:0]             in_op1;
  logic [OPW-1:0]             in_op2;
  logic [NCDB-1:0]            cdb_valid;
  logic [NCDB*TAG_W-1:0]      cdb_tag;
  logic [NCDB*XLEN-1:0]       cdb_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [31:0]                out_instr;
  logic [XLEN-1:0]            out_rs1;
  logic [XLEN-1:0]            out_rs2;
  logic [$clog2(DEPTH+1)-1:0] count;

  int checks   = 0;
  int failures = 0;

  id_operand_buffer #(
    .XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH), .NCDB(NCDB)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_op1(in_op1), .in_op2(in_op2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OPW-1:0] mkop(input logic v, input logic [TAG_W-1:0] t,
                                          input logic [XLEN-1:0] d);
    return {v, t, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] ins, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    in_valid = 1'b1;
    in_instr = ins;
    in_op1   = a;
    in_op2   = b;
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] next_id;
  int          mcount;
  logic        m_enq;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_op1    = '0;
    in_op2    = '0;
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
    out_ready = 1'b0;
    #1;
    chk("reset_count", count, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    tick();
    tick();
    rst = 1'b0;

    // Ready operands
    enq(32'h00208033, mkop(1, 0, 5), mkop(1, 0, 7));
    chk("ready_count", count, 1);
    chk("ready_out_valid", out_valid, 1);
    chk("ready_instr", out_instr, 32'h00208033);
    chk("ready_rs1", out_rs1, 5);
    chk("ready_rs2", out_rs2, 7);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ready_drain_count", count, 0);
    chk("ready_drain_valid", out_valid, 0);

    // Wakeup on channel 1
    enq(32'h000000A1, mkop(0, 7'h12, 0), mkop(1, 0, 3));
    chk("wake_wait_valid", out_valid, 0);
    chk("wake_wait_count", count, 1);
    cdb_valid = 2'b10;
    cdb_tag   = {7'h12, 7'h00};
    cdb_data  = {32'h0000DEAD, 32'h0};
    #1;
    chk("wake_no_comb_path", out_valid, 0);
    tick();
    cdb_valid = '0;
    chk("wake_valid", out_valid, 1);
    chk("wake_rs1", out_rs1, 32'hDEAD);
    chk("wake_rs2", out_rs2, 3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("wake_drain", count, 0);

    // Enqueue bypass on channel 0
    cdb_valid = 2'b01;
    cdb_tag   = {7'h00, 7'h33};
    cdb_data  = {32'h0, 32'h0000BEEF};
    enq(32'h000000B2, mkop(0, 7'h33, 0), mkop(1, 0, 4));
    cdb_valid = '0;
    chk("bypass_valid", out_valid, 1);
    chk("bypass_rs1", out_rs1, 32'hBEEF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bypass_drain", count, 0);

    // Full and wrap
    for (int i = 0; i < 4; i++) begin
      enq(32'h100 + i, mkop(1, 0, i), mkop(1, 0, 32'h10 + i));
      exp_q.push_back(32'h100 + i);
    end
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    next_id   = 32'h104;
    mcount    = 4;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_instr = next_id;
      in_op1   = mkop(1, 0, next_id);
      in_op2   = mkop(1, 0, 0);
      chk("wrap_head", out_instr, exp_q[0]);
      chk("wrap_in_ready", in_ready, (mcount < 4) ? 1 : 0);
      m_enq = (mcount < 4);
      tick();
      void'(exp_q.pop_front());
      if (m_enq) begin
        exp_q.push_back(next_id);
        next_id = next_id + 1;
      end else begin
        mcount = mcount - 1;
      end
      chk("wrap_count", count, mcount);
    end
    in_valid = 1'b0;
    while (exp_q.size() > 0) begin
      chk("drain_head", out_instr, exp_q[0]);
      chk("drain_rs1", out_rs1, exp_q[0]);
      void'(exp_q.pop_front());
      tick();
    end
    chk("drain_empty", count, 0);

    // Head blocking and lowest-channel priority
    enq(32'h000000C0, mkop(0, 7'h05, 0), mkop(1, 0, 9));
    enq(32'h000000C1, mkop(1, 0, 1), mkop(1, 0, 2));
    chk("block_count", count, 2);
    chk("block_valid", out_valid, 0);
    tick();
    chk("block_still", count, 2);
    cdb_valid = 2'b11;
    cdb_tag   = {7'h05, 7'h05};
    cdb_data  = {32'h22, 32'h11};
    tick();
    cdb_valid = '0;
    chk("prio_valid", out_valid, 1);
    chk("prio_rs1", out_rs1, 32'h11);
    chk("prio_instr", out_instr, 32'hC0);
    tick();
    chk("block_second", out_instr, 32'hC1);
    chk("block_second_valid", out_valid, 1);
    tick();
    out_ready = 1'b0;
    chk("block_empty", count, 0);

    // Flush
    for (int i = 0; i < 3; i++) enq(32'h200 + i, mkop(1, 0, i), mkop(1, 0, i));
    chk("flush_pre_count", count, 3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h2FF;
    in_op1    = mkop(0, 7'h44, 0);
    in_op2    = mkop(1, 0, 0);
    cdb_valid = 2'b01;
    cdb_tag   = {7'h00, 7'h44};
    #1;
    chk("flush_pre_valid", out_valid, 1);
    chk("flush_pre_ready", in_ready, 1);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    cdb_valid = '0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    tick();
    chk("flush_dropped", count, 0);

    // Asynchronous reset mid-run
    for (int i = 0; i < 3; i++) enq(32'h300 + i, mkop(1, 0, i), mkop(1, 0, i));
    chk("rst_pre_count", count, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_count", count, 0);
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_ready", in_ready, 1);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rst_idle_valid", out_valid, 0);
    chk("rst_idle_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
